// File: rtl/bram_ctrl_pkg.sv
// Shared types and constants for the BRAM port-B vector load controller.
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BRAM_ADDR_W      = 11;
    localparam int BRAM_DATA_W      = 32;
    localparam int BRAM_DEPTH       = 2048;
    localparam int REFRESH_PERIOD_W = 16;

endpackage

// File: rtl/bram_vector_load_ctrl_if.sv
// Handshake, vector and BRAM port-B signals of the vector load controller.
// slave: the controller side. master: the requester / BRAM side.
interface bram_vector_load_ctrl_if #(
    parameter int VLEN   = 1,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic                     busy;
    logic                     done;
    logic                     vec_valid;
    logic [DATA_W*VLEN-1:0]   vec;
    logic                     bram_en;
    logic [ADDR_W-1:0]        bram_addr;
    logic [DATA_W-1:0]        bram_dout;

    modport slave (
        input  start,
        input  base_addr,
        output busy,
        output done,
        output vec_valid,
        output vec,
        output bram_en,
        output bram_addr,
        input  bram_dout
    );

    modport master (
        output start,
        output base_addr,
        input  busy,
        input  done,
        input  vec_valid,
        input  vec,
        input  bram_en,
        input  bram_addr,
        output bram_dout
    );
endinterface

// File: rtl/bram_refresh_timer.sv
// Free-running refresh counter with a pending-refresh flag. Only instantiated
// when BRAM_LOAD_PERIODIC_EN is defined.
module bram_refresh_timer
    import bram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic consume,
    output logic pending
);
    logic [REFRESH_PERIOD_W-1:0] cnt;

    // Free-running period counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + REFRESH_PERIOD_W'(1);
        end
    end

    // Pending flag: set on terminal count, cleared when a load is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (cnt == '1) begin
            pending <= 1'b1;
        end else if (consume) begin
            pending <= 1'b0;
        end
    end
endmodule

// File: rtl/bram_vector_load_ctrl.sv
// Port-B sequencer: on an accepted start, reads VLEN consecutive words from
// base_addr (modulo depth) into a packed vector and flags it valid.
// Optional macro BRAM_LOAD_PERIODIC_EN adds a periodic self-triggered load.
module bram_vector_load_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int VLEN   = 1,
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
)(
    input  logic                   clk,
    input  logic                   rst,
    bram_vector_load_ctrl_if.slave bus
);
    localparam int               CNT_W    = $clog2(VLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VLEN - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       cap_cnt;
    logic [ADDR_W-1:0]      base_q;
    logic [DATA_W*VLEN-1:0] vec_q;
    logic                   vec_valid_q;
    logic                   start_req;
    logic                   load_accept;
    logic                   issue_en;
    logic                   cap_en;
    logic                   busy_c;
    logic                   done_c;

`ifdef BRAM_LOAD_PERIODIC_EN
    logic refresh_pending;

    bram_refresh_timer u_refresh (
        .clk     (clk),
        .rst     (rst),
        .consume (load_accept),
        .pending (refresh_pending)
    );

    // An external start and a pending refresh collapse into one load.
    assign start_req = bus.start | refresh_pending;
`else
    assign start_req = bus.start;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_nxt   = state;
        load_accept = 1'b0;
        issue_en    = 1'b0;
        cap_en      = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    load_accept = 1'b1;
                    state_nxt   = READ;
                end
            end
            READ: begin
                busy_c   = 1'b1;
                issue_en = 1'b1;
                // Read data lags the address by one cycle: nothing to capture
                // while issuing the first word.
                cap_en   = (issue_cnt != '0);
                if (issue_cnt == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy_c    = 1'b1;
                cap_en    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Base latch, issue/capture counters and the valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            vec_valid_q <= 1'b0;
        end else if (load_accept) begin
            base_q      <= bus.base_addr;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            if (issue_en) begin
                issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + CNT_W'(1);
            end
            if (cap_en) begin
                cap_cnt <= cap_cnt + CNT_W'(1);
            end
            if (state == DRAIN) begin
                vec_valid_q <= 1'b1;
            end
        end
    end

    // Vector capture: write the returning word into element cap_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q <= '0;
        end else if (cap_en) begin
            for (int unsigned k = 0; k < VLEN; k++) begin
                if (cap_cnt == CNT_W'(k)) begin
                    vec_q[DATA_W*k +: DATA_W] <= bus.bram_dout;
                end
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.bram_en   = issue_en;
    assign bus.bram_addr = issue_en ? (base_q + ADDR_W'(issue_cnt)) : '0;
    assign bus.vec       = vec_q;
    assign bus.vec_valid = vec_valid_q;
endmodule

// File: tb/tb_bram_vector_load_ctrl.sv
// Self-checking bench for bram_vector_load_ctrl: VLEN=4 and VLEN=1 instances
// against a word-array BRAM and a cycle-level reference of each load.
module tb_bram_vector_load_ctrl;
    import bram_ctrl_pkg::*;

    localparam int V4 = 4;

    logic        clk;
    logic        rst;
    logic [31:0] mem [0:BRAM_DEPTH-1];
    int          checks;
    int          failures;

    bram_vector_load_ctrl_if #(.VLEN(4), .ADDR_W(11), .DATA_W(32)) b4 ();
    bram_vector_load_ctrl_if #(.VLEN(1), .ADDR_W(11), .DATA_W(32)) b1 ();

    bram_vector_load_ctrl #(.VLEN(4), .ADDR_W(11), .DATA_W(32)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    bram_vector_load_ctrl #(.VLEN(1), .ADDR_W(11), .DATA_W(32)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block memory port B models, one-cycle read latency.
    always @(posedge clk) begin
        if (b4.bram_en) b4.bram_dout <= mem[b4.bram_addr];
        if (b1.bram_en) b1.bram_dout <= mem[b1.bram_addr];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One VLEN=4 load from base b, starting in the current (IDLE) cycle 0.
    // smask bit c raises start during cycle c of the load (must be ignored).
    task automatic load4(input logic [10:0] b, input logic [15:0] smask);
        logic [127:0] exp_vec;
        logic [10:0]  exp_addr;
        for (int k = 0; k < V4; k++) begin
            exp_vec[32*k +: 32] = mem[(int'(b) + k) % BRAM_DEPTH];
        end
        b4.base_addr = b;
        b4.start     = 1'b1;
        for (int c = 1; c <= V4 + 3; c++) begin
            step();
            b4.start     = smask[c];
            b4.base_addr = 11'($urandom);
            exp_addr     = 11'((int'(b) + c - 1) % BRAM_DEPTH);
            chk("load_bram_en", b4.bram_en, (c >= 1 && c <= V4));
            if (c <= V4) chk("load_bram_addr", b4.bram_addr, exp_addr);
            chk("load_busy", b4.busy, (c <= V4 + 1));
            chk("load_done", b4.done, (c == V4 + 2));
            chk("load_vec_valid", b4.vec_valid, (c >= V4 + 2));
            if (c == V4 + 2) chk("load_vec", b4.vec, exp_vec);
        end
        b4.start = 1'b0;
    endtask

    initial begin
        logic [10:0] base;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        b4.start = 1'b0;
        b4.base_addr = '0;
        b1.start = 1'b0;
        b1.base_addr = '0;
        for (int i = 0; i < BRAM_DEPTH; i++) mem[i] = $urandom;

        // Reset values.
        #2;
        chk("rst_busy", b4.busy, 1'b0);
        chk("rst_done", b4.done, 1'b0);
        chk("rst_vec_valid", b4.vec_valid, 1'b0);
        chk("rst_vec", b4.vec, '0);
        chk("rst_bram_en", b4.bram_en, 1'b0);
        chk("rst_bram_addr", b4.bram_addr, '0);
        chk("rst_vec1", b1.vec, '0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic load.
        for (int k = 0; k < V4; k++) mem[16 + k] = 32'hA0 + 32'(k);
        load4(11'h010, 16'h0000);
        chk("basic_vec_const", b4.vec, 128'h000000A3_000000A2_000000A1_000000A0);

        // Address wrap-around.
        load4(11'h7FE, 16'h0000);

        // Start pulses in READ (cycle 2) and DONE (cycle 6) are ignored.
        load4(11'($urandom), 16'h0044);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("ign_busy", b4.busy, 1'b0);
            chk("ign_done", b4.done, 1'b0);
            chk("ign_vec_valid", b4.vec_valid, 1'b1);
        end

        // Asynchronous reset mid-transfer.
        b4.base_addr = 11'h123;
        b4.start     = 1'b1;
        step();
        b4.start = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", b4.busy, 1'b0);
        chk("mid_rst_bram_en", b4.bram_en, 1'b0);
        chk("mid_rst_bram_addr", b4.bram_addr, '0);
        chk("mid_rst_done", b4.done, 1'b0);
        chk("mid_rst_vec_valid", b4.vec_valid, 1'b0);
        chk("mid_rst_vec", b4.vec, '0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("post_rst_done", b4.done, 1'b0);
            chk("post_rst_busy", b4.busy, 1'b0);
        end
        load4(11'h123, 16'h0000);

        // Randomized loads.
        repeat (6) begin
            base = 11'($urandom);
            for (int k = 0; k < V4; k++) mem[(int'(base) + k) % BRAM_DEPTH] = $urandom;
            load4(base, 16'h0000);
        end

        // VLEN=1 with start held high: one load every 4 cycles.
        base         = 11'($urandom);
        b1.base_addr = base;
        b1.start     = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk("cont_bram_en", b1.bram_en, (c % 4 == 1));
            if (c % 4 == 1) chk("cont_bram_addr", b1.bram_addr, base);
            chk("cont_busy", b1.busy, (c % 4 == 1 || c % 4 == 2));
            chk("cont_done", b1.done, (c % 4 == 3));
            chk("cont_vec_valid", b1.vec_valid, (c % 4 == 3 || c % 4 == 0));
            if (c % 4 == 3) chk("cont_vec", b1.vec, mem[base]);
        end
        b1.start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_vector_load_ctrl.md
Name: bram_vector_load_ctrl

Overview:
Sequencer for the PL-side read port (port B) of the 2048 x 32-bit block memory. It replaces free-running periodic scanning with an explicit start/busy/done handshake. On request it reads VLEN consecutive words from a programmable base address into a packed vector register, then flags the vector valid. It sits between the BRAM port B and the NN datapath that consumes the loaded vector.

Parameters:
VLEN, 1, number of 32-bit words loaded per transfer; legal range 1..2048
ADDR_W, 11, BRAM word-address width; depth is 2**ADDR_W
DATA_W, 32, BRAM word width

Ports:
clk  in  1  single clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  load request; sampled only in IDLE
base_addr  in  ADDR_W  word address of element 0; sampled with the accepted start
busy  out  1  transfer in progress (READ or DRAIN)
done  out  1  one-cycle pulse when the transfer completes
vec_valid  out  1  vec holds a complete load; cleared on the next accepted start
vec  out  DATA_W*VLEN  loaded vector; element k at bits [DATA_W*k +: DATA_W]
bram_en  out  1  port B enable
bram_addr  out  ADDR_W  port B word address
bram_dout  in  DATA_W  port B read data; 1-cycle read latency

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, vec_valid=0, vec=0, bram_en=0, bram_addr=0; issue and capture counters = 0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: if start=1, latch base_addr, clear vec_valid, go to READ. Otherwise stay in IDLE. vec keeps its value.
- READ: bram_en=1 and bram_addr=base+k for issue index k=0..VLEN-1, one address per cycle.
  - In the cycle issuing k≥1, bram_dout holds word k-1, and it is written into vec element k-1 at the end of that cycle.
  - After k=VLEN-1 is issued, go to DRAIN.
- DRAIN: bram_en=0. Capture word VLEN-1. Go to DONE.
- DONE: done=1 and vec_valid=1 for this cycle; vec_valid stays high afterwards. Go to IDLE.
- Timing, with start accepted in cycle T:
  - READ occupies cycles T+1..T+VLEN.
  - DRAIN is cycle T+VLEN+1.
  - done is high in cycle T+VLEN+2.
  - busy is high in T+1..T+VLEN+1.
  - Start-to-done latency = VLEN+2 cycles.
- Addresses are computed modulo 2**ADDR_W: base+k wraps from 2**ADDR_W-1 to 0. There is no error flag.
- start outside IDLE (READ, DRAIN, DONE) is ignored, not queued.
- start held high: a new load begins in each IDLE cycle, so back-to-back loads repeat every VLEN+3 cycles.
- Reset mid-transfer: immediate return to IDLE, vec cleared, no done pulse.
- vec elements not yet captured keep their previous contents until overwritten. Consumers qualify vec with vec_valid.
- Issue counter width: clog2(VLEN)+1 bits. VLEN=1 is a legal corner case (READ lasts one cycle).

Optional Feature:
Macro BRAM_LOAD_PERIODIC_EN.
- Defined: a 16-bit free-running refresh counter, reset to 0, sets a pending-refresh flag each time it reaches 16'hFFFF. When the flag is set and state is IDLE, a load starts exactly as if start=1, using the current base_addr, and the flag clears. A refresh arriving while busy stays pending until IDLE. A simultaneous external start and pending refresh produce one load and clear the flag.
- Not defined: the counter and flag are absent; loads occur only on external start.

Decomposition:
- Shared package bram_ctrl_pkg:
  - state enum (IDLE, READ, DRAIN, DONE), 2-bit encoding
  - BRAM_ADDR_W=11, BRAM_DATA_W=32, BRAM_DEPTH=2048
  - REFRESH_PERIOD_W=16
- One sub-module, bram_refresh_timer: counter plus pending flag, instantiated only under BRAM_LOAD_PERIODIC_EN. The FSM and capture logic stay in the top.

Test Plan:
- Basic load: VLEN=4, BRAM[0x010..0x013]=0xA0..0xA3, start pulse in cycle 0, base 0x010 -> bram_addr 0x010..0x013 in cycles 1-4, bram_en high only then, busy cycles 1-5, done cycle 6, vec=0x000000A3_000000A2_000000A1_000000A0, vec_valid=1 from cycle 6.
- Wrap-around: VLEN=4, base 0x7FE -> addresses 0x7FE, 0x7FF, 0x000, 0x001; vec elements match those locations.
- Ignored start: start pulsed at cycles 2 and 6 of a VLEN=4 load -> no effect, single done, next load only after start in IDLE.
- Reset mid-op: assert rst asynchronously in cycle 3 of a load -> outputs immediately at reset values, vec=0, no done; a later start completes normally.
- Continuous start, VLEN=1: start tied high -> done every 4 cycles, bram_addr=base each load.
- With BRAM_LOAD_PERIODIC_EN: no external start; load begins the cycle after the counter hits 0xFFFF. If a refresh arrives during a user load, the refresh load starts in the first IDLE cycle after that load's done.
